serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands one bit per cycle, LSB first.
- Each step uses a single shared 1-bit adder cell: two cascaded half adders plus an OR for carry-out, with a registered carry between bits.
- Presents a start/ready/done handshake to the surrounding datapath and holds the result until the next accepted operation.
- Trades latency for area versus a parallel ripple adder; it is the controller the team uses to time-multiplex the half-adder cell.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only when ready=1
A  input  WIDTH  operand A, sampled on the accepting edge only
B  input  WIDTH  operand B, sampled on the accepting edge only
ready  output  1  high in IDLE; start accepted this cycle if asserted
busy  output  1  high in RUN
done  output  1  one-cycle pulse, high in DONE
S  output  WIDTH  registered sum, valid from done onward
C  output  1  registered carry-out, valid from done onward

Behaviour:
- Reset:
  - Takes effect on any edge where rst=1, in every state including mid-RUN.
  - State=IDLE; ready=1, busy=0, done=0, S=0, C=0.
  - Shift registers, step counter and internal carry are cleared.
  - An in-flight operation is discarded; no done pulse follows.
  - rst has priority over start on the same edge.
- States:
  - IDLE: ready=1. On start=1 at edge k: latch A into shift register sa, latch B into sb, clear carry c, clear counter cnt, go to RUN.
  - RUN: busy=1. Lasts exactly WIDTH cycles (edges k+1..k+WIDTH). On each edge:
    - h1 = sa[0]^sb[0]; g1 = sa[0]&sb[0]
    - sum bit = h1^c; c <= g1 | (h1&c)
    - The sum bit is shifted into the MSB of the accumulator; sa and sb shift right by 1; cnt increments.
    - On the edge where cnt=WIDTH-1: load S with the completed accumulator and C with the final carry, then go to DONE.
  - DONE: done=1 for exactly one cycle (the cycle after edge k+WIDTH). Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge k -> done high and S/C valid in the cycle following edge k+WIDTH, i.e. WIDTH+1 cycles from the accepting edge. Throughput is one operation per WIDTH+2 cycles.
- start:
  - Ignored in RUN and DONE; it is not queued.
  - Changes to A/B after the accepting edge have no effect.
  - A start held high continuously is re-accepted on the first IDLE cycle after DONE.
- Outputs S and C change only at the RUN->DONE transition or on reset, and hold otherwise, including through IDLE and the next RUN.
- Arithmetic: {C,S} = A+B modulo 2^(WIDTH+1). No carry-in; no overflow flag beyond C.
- cnt is $clog2(WIDTH) bits wide minimum and never wraps in legal operation.
- ready, busy and done are one-hot across IDLE/RUN/DONE; exactly one is high every cycle after reset.
- No combinational path from inputs to outputs.

Test Plan:
1. rst=1 for 2 cycles, then 0 -> ready=1, busy=0, done=0, S=0x00, C=0. Repeat with start=1 held during reset -> no operation is accepted until the first edge with rst=0.
2. WIDTH=8, A=0x5A, B=0x3C, single-cycle start -> busy high 8 cycles; done pulses 9 cycles after the accepting edge with S=0x96, C=0. S/C hold after done drops.
3. Corner sums:
   - A=0xFF, B=0x01 -> S=0x00, C=1
   - A=0xFF, B=0xFF -> S=0xFE, C=1
   - A=0x00, B=0x00 -> S=0x00, C=0
   - Bench compares every case against a behavioural A+B model.
4. Start with A=0x12, B=0x34; during RUN pulse start with A=0xFF, B=0xFF -> second request ignored; result S=0x46, C=0; exactly one done pulse.
5. Start with A=0xF0, B=0x0F; assert rst at RUN cycle 4 -> next cycle is IDLE with S=0, C=0, ready=1, and no done pulse. A fresh start afterwards with A=0x01, B=0x01 -> S=0x02.
6. start held high continuously, operands changed once per op (0x80+0x80, then 0x7F+0x01) -> back-to-back ops every 10 cycles. First op: S=0x00, C=1. Second op: S=0x80, C=0. Repeat a random 200-pair run with WIDTH=4 against the model.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared 1-bit adder cell (two half adders plus
// an OR for carry-out) is time-multiplexed over WIDTH cycles, LSB first. The
// finished sum and carry are held until the next operation completes or reset.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic h1, g1, g2, sum_bit, carry_nxt;

    // Shared adder cell: first half adder on the operand bits, second on the carry.
    always_comb begin
        h1        = sa_q[0] ^ sb_q[0];
        g1        = sa_q[0] & sb_q[0];
        sum_bit   = h1 ^ c_q;
        g2        = h1 & c_q;
        carry_nxt = g1 | g2;
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        s_d     = s_q;
        c_d     = c_q;
        co_d    = co_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    acc_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                acc_d = {sum_bit, acc_q[WIDTH-1:1]};
                c_d   = carry_nxt;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    // Last bit: publish result; counter is left alone so it never wraps.
                    s_d     = acc_d;
                    co_d    = carry_nxt;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            c_q     <= c_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        ready = (state_q == StIdle);
        busy  = (state_q == StRun);
        done  = (state_q == StDone);
        S     = s_q;
        C     = co_q;
    end

endmodule
